mct_rd_scheduler: RTL and testbench
===================================

MCT_RD_SCHEDULER -- requirements
Module: mct_rd_scheduler

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 64: byte address width.
REQ-002 SHALL have parameter C_XFER_WIDTH, default 32: total-beat count width.
REQ-003 SHALL have parameter C_BYTES_PER_BEAT, default 64: bytes per data beat (power of 2).
REQ-004 SHALL have parameter C_MAX_BURST, default 64: beats per full burst (power of 2, at most 256).
REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 16: maximum bursts in flight (at least 1).
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_start  in  1  one-cycle start pulse.
- ctrl_addr  in  C_ADDR_WIDTH  start byte address, aligned to C_MAX_BURST*C_BYTES_PER_BEAT.
- ctrl_num_beats  in  C_XFER_WIDTH  total beats to read.
- ctrl_busy  out  1  transfer in progress.
- ctrl_done  out  1  one-cycle completion pulse.
- ctrl_err  out  1  sticky protocol error.
- ar_valid  out  1  read-address valid.
- ar_ready  in  1  read-address ready.
- ar_addr  out  C_ADDR_WIDTH  burst byte address.
- ar_len  out  8  burst beats minus 1.
- burst_done  in  1  one-cycle pulse per completed burst (last beat accepted).

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE.
REQ-008 IDLE: ctrl_start latches addr/num_beats; num_beats=0 -> DONE, else -> ISSUE; ctrl_start in any other state SHALL be ignored.
REQ-009 SHALL compute burst count as ceil(num_beats/C_MAX_BURST); every burst has C_MAX_BURST beats except the last, which has num_beats mod C_MAX_BURST beats when that remainder is nonzero.
REQ-010 ISSUE: ar_valid SHALL be asserted when outstanding < C_MAX_OUTSTANDING, and SHALL first be asserted the cycle after the accepted ctrl_start.
REQ-011 Once asserted, ar_valid, ar_addr and ar_len SHALL be held stable until ar_valid & ar_ready.
REQ-012 On each AR handshake: ar_addr SHALL advance by C_MAX_BURST*C_BYTES_PER_BEAT, remaining bursts SHALL decrement, and outstanding SHALL increment.
REQ-013 Each burst_done SHALL decrement outstanding; a handshake and burst_done in the same cycle SHALL leave outstanding unchanged.
REQ-014 When the last burst's handshake completes, FSM SHALL go ISSUE -> DRAIN.
REQ-015 DRAIN: FSM SHALL go to DONE in the cycle after outstanding reaches 0.
REQ-016 DONE: ctrl_done SHALL pulse for exactly 1 cycle, then FSM -> IDLE.
REQ-017 ctrl_busy SHALL be 1 in ISSUE and DRAIN only.
REQ-018 burst_done while outstanding = 0 SHALL set ctrl_err and leave outstanding at 0 (no wrap).
REQ-019 ctrl_err SHALL clear only on rst or on an accepted ctrl_start.
REQ-020 An outstanding-count overflow SHALL be impossible by construction (REQ-010).

Reset
REQ-021 rst SHALL take priority over all inputs, including mid-transfer: FSM -> IDLE, and all counters and latched registers SHALL clear.
REQ-022 After rst, every output (ar_valid, ar_addr, ar_len, ctrl_busy, ctrl_done, ctrl_err) SHALL be 0 in the following cycle.
REQ-023 In-flight bursts dropped by rst SHALL NOT be tracked; their burst_done pulses after reset SHALL set ctrl_err.

Structure
REQ-024 The FSM state enum and the derived constants (burst byte stride, log2 of C_MAX_BURST, outstanding counter width) SHALL reside in package mct_rd_pkg.
REQ-025 Outstanding and remaining-burst tracking SHALL each use one mct_counter instance (load/incr/decr/is_zero) with clken tied high.
REQ-026 The remaining-burst counter's is_zero SHALL drive the ISSUE -> DRAIN decision.
REQ-027 The outstanding counter's is_zero SHALL drive the DRAIN -> DONE decision.

Verification
REQ-028 Start addr 0x1000, num_beats=128, ar_ready=1, burst_done 10 cycles after each handshake -> 2 ARs, addr 0x1000 and 0x2000, ar_len 63, then one ctrl_done.
REQ-029 num_beats=130 -> 3 ARs with ar_len 63, 63, 1; ctrl_done only after the third burst_done.
REQ-030 num_beats=64*40, burst_done withheld -> exactly 16 ARs, ar_valid stays 0; each burst_done releases exactly one further AR.
REQ-031 ar_ready held low 5 cycles -> ar_addr/ar_len stable throughout; handshake + burst_done in same cycle -> outstanding unchanged.
REQ-032 num_beats=0 -> ctrl_done 2 cycles after ctrl_start, no ar_valid; spurious burst_done while idle -> ctrl_err=1, cleared by the next ctrl_start.
REQ-033 rst asserted in ISSUE with 3 outstanding -> all outputs 0 next cycle; a later ctrl_start runs a clean transfer.

Source files
------------

// File: rtl/mct_rd_pkg.sv
// Shared FSM state type and derived-constant helpers for the read-burst scheduler.
package mct_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Byte distance between consecutive burst start addresses.
    function automatic int unsigned burst_stride(input int unsigned max_burst,
                                                 input int unsigned bytes_per_beat);
        return max_burst * bytes_per_beat;
    endfunction

    function automatic int unsigned log2_burst(input int unsigned max_burst);
        return $clog2(max_burst);
    endfunction

    // Wide enough to hold max_out itself, not just max_out-1.
    function automatic int unsigned outstanding_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/mct_counter.sv
// Loadable up/down counter that saturates at zero, with a registered zero flag.
module mct_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clken,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         incr,
    input  logic         decr,
    output logic [W-1:0] count,
    output logic         is_zero
);

    logic [W-1:0] count_next;

    // Simultaneous incr and decr cancel; decr at zero holds at zero.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (incr && !decr) begin
            count_next = count + W'(1);
        end else if (decr && !incr && (count != '0)) begin
            count_next = count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            is_zero <= 1'b1;
        end else if (clken) begin
            count   <= count_next;
            is_zero <= (count_next == '0);
        end
    end

endmodule

// File: rtl/mct_rd_scheduler.sv
// Splits a beat-count read request into aligned AR bursts, bounding bursts in flight.
module mct_rd_scheduler
    import mct_rd_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_XFER_WIDTH      = 32,
    parameter int unsigned C_BYTES_PER_BEAT  = 64,
    parameter int unsigned C_MAX_BURST       = 64,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_XFER_WIDTH-1:0] ctrl_num_beats,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    output logic                    ctrl_err,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [C_ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]              ar_len,
    input  logic                    burst_done
);

    localparam int unsigned LOG2_BURST = log2_burst(C_MAX_BURST);
    localparam int unsigned OUT_W      = outstanding_width(C_MAX_OUTSTANDING);
    localparam int unsigned REM_W      = C_XFER_WIDTH - LOG2_BURST + 1;
    localparam int unsigned STRIDE     = burst_stride(C_MAX_BURST, C_BYTES_PER_BEAT);

    state_t                  state;
    logic [7:0]              last_len;
    logic                    hs;
    logic                    start_acc;
    logic [C_XFER_WIDTH-1:0] rem_beats;
    logic [REM_W-1:0]        num_bursts;
    logic [7:0]              start_len;
    logic [REM_W-1:0]        rem_count;
    logic                    rem_is_zero;
    logic [REM_W-1:0]        rem_after;
    logic [OUT_W-1:0]        out_count;
    logic                    out_is_zero;
    logic [OUT_W-1:0]        out_after;
    logic                    issue_more;

    assign hs        = ar_valid & ar_ready;
    assign start_acc = ctrl_start & (state == ST_IDLE);

    mct_counter #(.W(REM_W)) u_rem_cnt (
        .clk      (clk),
        .rst      (rst),
        .clken    (1'b1),
        .load     (start_acc),
        .load_val (num_bursts),
        .incr     (1'b0),
        .decr     (hs),
        .count    (rem_count),
        .is_zero  (rem_is_zero)
    );

    mct_counter #(.W(OUT_W)) u_out_cnt (
        .clk      (clk),
        .rst      (rst),
        .clken    (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .incr     (hs),
        .decr     (burst_done),
        .count    (out_count),
        .is_zero  (out_is_zero)
    );

    // Request geometry and the post-cycle view of both counters for the next ar_valid.
    always_comb begin
        rem_beats  = ctrl_num_beats & C_XFER_WIDTH'(C_MAX_BURST - 1);
        num_bursts = REM_W'(ctrl_num_beats >> LOG2_BURST) + REM_W'(rem_beats != '0);
        start_len  = (rem_beats == '0) ? 8'(C_MAX_BURST - 1)
                                       : 8'(rem_beats - C_XFER_WIDTH'(1));
        rem_after  = rem_count - REM_W'(hs);
        out_after  = out_count;
        case ({hs, burst_done})
            2'b10:   out_after = out_count + OUT_W'(1);
            2'b01:   out_after = out_is_zero ? out_count : out_count - OUT_W'(1);
            default: out_after = out_count;
        endcase
        issue_more = (rem_after != '0) && (out_after < OUT_W'(C_MAX_OUTSTANDING));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ar_valid  <= 1'b0;
            ar_addr   <= '0;
            ar_len    <= '0;
            last_len  <= '0;
            ctrl_busy <= 1'b0;
            ctrl_done <= 1'b0;
            ctrl_err  <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            ctrl_err  <= (ctrl_err & ~start_acc) | (burst_done & out_is_zero);
            case (state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        ar_addr  <= ctrl_addr;
                        last_len <= start_len;
                        ar_len   <= (num_bursts == REM_W'(1)) ? start_len : 8'(C_MAX_BURST - 1);
                        if (ctrl_num_beats == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_ISSUE;
                            ar_valid  <= 1'b1;
                            ctrl_busy <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        ar_addr <= ar_addr + C_ADDR_WIDTH'(STRIDE);
                        ar_len  <= (rem_after == REM_W'(1)) ? last_len : 8'(C_MAX_BURST - 1);
                    end
                    if (!ar_valid || hs) begin
                        ar_valid <= issue_more;
                    end
                    if (rem_is_zero) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_is_zero) begin
                        state     <= ST_DONE;
                        ctrl_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    ctrl_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mct_rd_scheduler.sv
// Directed scoreboard bench for mct_rd_scheduler with default parameters.
module tb_mct_rd_scheduler;

    localparam int BD_DELAY = 10;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_start;
    logic [63:0] ctrl_addr;
    logic [31:0] ctrl_num_beats;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        ctrl_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        burst_done;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  ar_cnt   = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_bd_cyc = 0;
    bit  auto_bd  = 1'b0;
    ar_t exp_q[$];
    int  due_q[$];

    mct_rd_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_start     (ctrl_start),
        .ctrl_addr      (ctrl_addr),
        .ctrl_num_beats (ctrl_num_beats),
        .ctrl_busy      (ctrl_busy),
        .ctrl_done      (ctrl_done),
        .ctrl_err       (ctrl_err),
        .ar_valid       (ar_valid),
        .ar_ready       (ar_ready),
        .ar_addr        (ar_addr),
        .ar_len         (ar_len),
        .burst_done     (burst_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any AR handshake, schedule its burst_done, then sample after the edge.
    task automatic tick();
        ar_t e;
        if (ar_valid && ar_ready) begin
            ar_cnt++;
            if (exp_q.size() == 0) begin
                check("ar_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ar_addr", ar_addr, e.addr);
                check("ar_len", 64'(ar_len), 64'(e.len));
            end
            if (auto_bd) due_q.push_back(cyc + BD_DELAY);
        end
        if (burst_done) last_bd_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (ctrl_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        burst_done = 1'b0;
        if (auto_bd && due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            burst_done = 1'b1;
        end
    endtask

    task automatic start_xfer(input logic [63:0] addr, input int nb);
        int nbursts;
        ar_t e;
        nbursts = (nb + 63) / 64;
        for (int i = 0; i < nbursts; i++) begin
            e.addr = addr + 64'(i) * 64'h1000;
            e.len  = (i == nbursts - 1 && (nb % 64) != 0) ? 8'((nb % 64) - 1) : 8'd63;
            exp_q.push_back(e);
        end
        ctrl_addr      = addr;
        ctrl_num_beats = 32'(nb);
        ctrl_start     = 1'b1;
        tick();
        ctrl_start     = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Return one burst_done per cycle for every burst the bench knows is in flight.
    task automatic drain_manual(input int outstanding, input int budget, input string tag);
        int out;
        int d0;
        int a0;
        int n;
        out = outstanding;
        d0  = done_cnt;
        n   = 0;
        while (done_cnt == d0 && n < budget) begin
            a0 = ar_cnt;
            if (out > 0) begin
                burst_done = 1'b1;
                out--;
            end
            tick();
            out += ar_cnt - a0;
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar_valid"}, 64'(ar_valid), 64'd0);
        check({tag, "_ar_addr"}, ar_addr, 64'd0);
        check({tag, "_ar_len"}, 64'(ar_len), 64'd0);
        check({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
        check({tag, "_done"}, 64'(ctrl_done), 64'd0);
        check({tag, "_err"}, 64'(ctrl_err), 64'd0);
    endtask

    initial begin
        int a0;
        int n;
        rst            = 1'b1;
        ctrl_start     = 1'b0;
        ctrl_addr      = '0;
        ctrl_num_beats = '0;
        ar_ready       = 1'b0;
        burst_done     = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Two full bursts, auto completion.
        auto_bd  = 1'b1;
        ar_ready = 1'b1;
        a0 = ar_cnt;
        start_xfer(64'h1000, 128);
        check("first_ar_valid", 64'(ar_valid), 64'd1);
        check("busy_issue", 64'(ctrl_busy), 64'd1);
        run_until_done(200, "done_128");
        check("ar_count_128", 64'(ar_cnt - a0), 64'd2);
        check("busy_after", 64'(ctrl_busy), 64'd0);
        tick();
        check("done_one_cycle", 64'(ctrl_done), 64'd0);
        check("err_clean", 64'(ctrl_err), 64'd0);

        // Partial last burst; completion strictly after the last burst_done.
        a0 = ar_cnt;
        start_xfer(64'h10000, 130);
        run_until_done(200, "done_130");
        check("ar_count_130", 64'(ar_cnt - a0), 64'd3);
        check("done_after_last_bd", 64'(done_cyc > last_bd_cyc), 64'd1);
        tick();

        // Outstanding limit with burst_done withheld.
        auto_bd = 1'b0;
        a0 = ar_cnt;
        start_xfer(64'h100000, 64 * 40);
        repeat (40) tick();
        check("limit_ar_count", 64'(ar_cnt - a0), 64'd16);
        check("limit_ar_valid", 64'(ar_valid), 64'd0);
        for (int k = 1; k <= 2; k++) begin
            burst_done = 1'b1;
            tick();
            repeat (5) tick();
            check("release_ar_count", 64'(ar_cnt - a0), 64'(16 + k));
            check("release_ar_valid", 64'(ar_valid), 64'd0);
        end
        drain_manual(16, 400, "done_limit");
        check("limit_total", 64'(ar_cnt - a0), 64'd40);
        tick();

        // Backpressure hold, then handshake coinciding with a burst_done.
        ar_ready = 1'b0;
        a0 = ar_cnt;
        start_xfer(64'h40000, 128);
        for (int i = 0; i < 5; i++) begin
            check("hold1_valid", 64'(ar_valid), 64'd1);
            check("hold1_addr", ar_addr, 64'h40000);
            check("hold1_len", 64'(ar_len), 64'd63);
            tick();
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold2_valid", 64'(ar_valid), 64'd1);
            check("hold2_addr", ar_addr, 64'h41000);
            check("hold2_len", 64'(ar_len), 64'd63);
            tick();
        end
        ar_ready   = 1'b1;
        burst_done = 1'b1;
        tick();
        ar_ready = 1'b0;
        n = done_cnt;
        repeat (8) tick();
        check("no_early_done", 64'(done_cnt - n), 64'd0);
        check("busy_drain", 64'(ctrl_busy), 64'd1);
        check("err_after_overlap", 64'(ctrl_err), 64'd0);
        burst_done = 1'b1;
        tick();
        run_until_done(20, "done_overlap");
        check("err_after_overlap_done", 64'(ctrl_err), 64'd0);
        tick();

        // Zero-beat request and a spurious burst_done.
        start_xfer(64'h2000, 0);
        check("zero_done_c1", 64'(ctrl_done), 64'd0);
        check("zero_ar_valid", 64'(ar_valid), 64'd0);
        check("zero_busy", 64'(ctrl_busy), 64'd0);
        tick();
        check("zero_done_c2", 64'(ctrl_done), 64'd1);
        check("zero_ar_valid2", 64'(ar_valid), 64'd0);
        tick();
        burst_done = 1'b1;
        tick();
        check("spurious_err", 64'(ctrl_err), 64'd1);
        repeat (3) tick();
        check("err_sticky", 64'(ctrl_err), 64'd1);
        auto_bd  = 1'b1;
        ar_ready = 1'b1;
        start_xfer(64'h3000, 64);
        check("err_cleared", 64'(ctrl_err), 64'd0);
        run_until_done(100, "done_after_err");
        tick();

        // Reset mid-transfer with three bursts in flight.
        auto_bd = 1'b0;
        a0 = ar_cnt;
        start_xfer(64'h0, 64 * 8);
        n = 0;
        while ((ar_cnt - a0) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("pre_rst_ar_count", 64'(ar_cnt - a0), 64'd3);
        ar_ready = 1'b0;
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        exp_q.delete();
        rst = 1'b0;
        tick();
        burst_done = 1'b1;
        tick();
        check("dropped_bd_err", 64'(ctrl_err), 64'd1);
        auto_bd  = 1'b1;
        ar_ready = 1'b1;
        a0 = ar_cnt;
        start_xfer(64'h8000, 192);
        check("post_rst_err_clear", 64'(ctrl_err), 64'd0);
        run_until_done(200, "done_post_rst");
        check("post_rst_ar_count", 64'(ar_cnt - a0), 64'd3);
        check("post_rst_err", 64'(ctrl_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
